fp32_packed_to_ieee_converter: RTL and testbench
================================================

Name: fp32_packed_to_ieee_converter

Overview:
- Converts the packed multiplier result word back into IEEE-754 binary32. Packed word: {exponent[7:0], signed two's-complement mantissa[23:0]}.
- Sits downstream of the multiplier rounding stage, feeding accumulator/writeback logic that expects standard fp32.
- 3-stage pipeline with valid/ready flow control.
- Includes a bypass mode: a non-conversion word passes through unchanged at the same latency. Saturating event counters record overflow and flush-to-zero.

Parameters:
EXPONENT_WIDTH, 8, packed and IEEE exponent width
MANTISSA_WIDTH, 24, packed signed mantissa width (Q1.22, bit 23 = sign)
FRACTION_WIDTH, 23, IEEE fraction width
CNT_WIDTH, 16, width of each saturating event counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
i_valid  in  1  input word valid
i_ready  out  1  converter can accept a word this cycle
i_conv_op  in  1  1: convert i_data; 0: pass i_data through unchanged
i_data  in  EXPONENT_WIDTH+MANTISSA_WIDTH  packed word {exp, mant}
o_valid  out  1  output word valid
o_ready  in  1  downstream accepts o_data
o_data  out  32  IEEE binary32 result, or bypassed word
i_cnt_clear  in  1  synchronous clear of both counters
o_ovf_cnt  out  CNT_WIDTH  saturating count of overflow-to-infinity events
o_unf_cnt  out  CNT_WIDTH  saturating count of flush-to-zero events

Behaviour:
- Reset (async, active-high): all stage valids, o_valid, o_data, and both counters go to 0. i_ready = 1 after reset.
- Pipeline enable: adv = ~o_valid | o_ready. All three stages shift together when adv is high. i_ready = adv. A word is accepted when i_valid & i_ready.
- Latency: exactly 3 cycles from accept to o_valid when there is no stall. o_data and o_valid hold stable while o_valid & ~o_ready.
- Bubbles are not compressed. Throughput is 1 word/cycle.
- Value semantics: value = mant × 2^-22 × 2^(exp−127), so mant 0x400000 represents 1.0.
- S1: latch exp, mant, and conv_op. sign = mant[23]. mag = |mant| as 24-bit unsigned; 0x800000 yields mag 0x800000 with no overflow.
- S2: leading-one position p (0..23) of mag; zero flag when mag = 0. norm = mag << (23−p), which puts the leading one at bit 23.
- S3 arithmetic: e = exp + p − 22, computed as a signed 10-bit value.
- S3 result selection, in priority order:
  - mag = 0: output +0 (0x00000000). No counter change.
  - e ≥ 255: output {sign, 8'hFF, 23'h0} (infinity). o_ovf_cnt increments.
  - e ≤ 0: output {sign, 31'h0} (signed zero, denormals flushed). o_unf_cnt increments.
  - Otherwise: output {sign, e[7:0], norm[22:0]}.
- Conversion is exact; no rounding is needed. For mag ≤ 0x7FFFFF, p ≤ 22. The p = 23 case only occurs for mag = 0x800000, whose dropped bits are all zero.
- Bypass (conv_op = 0): o_data = i_data unchanged. Flags and counters are not affected.
- Counters:
  - Increment only on the cycle the flagged word enters the output register.
  - Saturate at all-ones.
  - i_cnt_clear has priority over a same-cycle increment; the result is 0.
- Reset mid-operation discards all in-flight words. No partial output is produced.
- i_data and i_conv_op are don't-care when i_valid = 0.

Decomposition:
- Shared package fp32_pkg: EXPONENT_WIDTH, MANTISSA_WIDTH, FRACTION_WIDTH, EXP_BIAS = 127, Q-point constant MANT_POINT = 22, EXP_MAX = 255, and the positive-infinity and zero constants.
- One sub-module, lzc24: combinational 24-bit leading-one detector producing p[4:0] and a zero flag. It is instantiated in S2.

Test Plan:
- Convert {8'h7F, 24'h400000} -> o_data 0x3F800000 three cycles later. Convert {8'h7F, 24'hC00000} -> 0xBF800000.
- Convert {8'h7F, 24'h800000} (−2.0) -> 0xC0000000. Convert {8'h80, 24'h7FFFFF} -> 0x407FFFFE.
- Convert {8'hFF, 24'h400000} -> 0x7F800000 and o_ovf_cnt = 1. Convert {8'h00, 24'h400000} -> 0x00000000 and o_unf_cnt = 1. Convert {8'h55, 24'h000000} -> 0x00000000 with no count change.
- Bypass: i_conv_op = 0 with i_data 0xDEADBEEF -> o_data 0xDEADBEEF after 3 cycles, counters unchanged.
- Backpressure: stream 5 words, hold o_ready = 0 for 4 cycles -> i_ready goes low, o_data is held, all 5 outputs appear in order with none lost or duplicated. Assert rst mid-stream -> o_valid = 0 immediately and no stale word emerges afterwards.
- Counters: preload via 2^CNT_WIDTH overflow events -> o_ovf_cnt stays 0xFFFF. Assert i_cnt_clear in the same cycle as an overflow event -> counter reads 0.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared widths and constants for the packed-to-IEEE binary32 converter.
// The packed mantissa is signed Q1.22, so 0x400000 represents 1.0.
package fp32_pkg;
    localparam int EXPONENT_WIDTH = 8;
    localparam int MANTISSA_WIDTH = 24;
    localparam int FRACTION_WIDTH = 23;
    localparam int DATA_WIDTH     = EXPONENT_WIDTH + MANTISSA_WIDTH;
    localparam int EXP_BIAS       = 127;
    localparam int MANT_POINT     = 22;
    localparam int EXP_MAX        = 255;

    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        RES_NORMAL,
        RES_ZERO,
        RES_OVF,
        RES_UNF
    } res_kind_e;

    // 0x800000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [MANTISSA_WIDTH-1:0] mant_abs(input logic [MANTISSA_WIDTH-1:0] m);
        return m[MANTISSA_WIDTH-1] ? (~m + 1'b1) : m;
    endfunction
endpackage

// File: rtl/lzc24.sv
// Combinational leading-one detector for a 24-bit magnitude.
module lzc24 (
    input  logic [23:0] mag,
    output logic [4:0]  pos,
    output logic        zero
);
    always_comb begin
        pos = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (mag[i]) pos = i[4:0];
        end
        zero = (mag == 24'd0);
    end
endmodule

// File: rtl/fp32_packed_to_ieee_converter.sv
// Three-stage packed {exp, signed mant} to IEEE binary32 converter with bypass,
// valid/ready flow control and saturating overflow / flush-to-zero counters.
module fp32_packed_to_ieee_converter
    import fp32_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic                  i_conv_op,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [31:0]           o_data,
    input  logic                  i_cnt_clear,
    output logic [CNT_WIDTH-1:0]  o_ovf_cnt,
    output logic [CNT_WIDTH-1:0]  o_unf_cnt
);
    logic                      adv;
    logic                      v1, conv1;
    logic [DATA_WIDTH-1:0]     raw1;
    logic [MANTISSA_WIDTH-1:0] mag1;
    logic                      v2, conv2, zero2;
    logic [DATA_WIDTH-1:0]     raw2;
    logic [4:0]                pos2;
    logic [FRACTION_WIDTH-1:0] norm2;
    logic [4:0]                pos;
    logic                      zero;
    logic signed [9:0]         e;
    res_kind_e                 kind;
    logic [31:0]               result;
    logic                      sign;
    logic                      ovf_evt, unf_evt;

    assign adv     = ~o_valid | o_ready;
    assign i_ready = adv;

    lzc24 u_lzc (
        .mag  (mag1),
        .pos  (pos),
        .zero (zero)
    );

    // Raw word rides along every stage so bypass keeps the same latency.
    always_comb begin
        sign = raw2[MANTISSA_WIDTH-1];
        e    = $signed({2'b00, raw2[DATA_WIDTH-1 -: EXPONENT_WIDTH]})
             + $signed({5'b00000, pos2})
             - $signed(10'(MANT_POINT));
        kind = RES_NORMAL;
        if (zero2)                             kind = RES_ZERO;
        else if (e >= $signed(10'(EXP_MAX)))   kind = RES_OVF;
        else if (e <= 10'sd0)                  kind = RES_UNF;
        case (kind)
            RES_ZERO: result = FP32_ZERO;
            RES_OVF:  result = FP32_POS_INF | {sign, 31'h0};
            RES_UNF:  result = {sign, 31'h0};
            default:  result = {sign, e[7:0], norm2};
        endcase
        if (!conv2) result = raw2;
        ovf_evt = v2 & conv2 & (kind == RES_OVF);
        unf_evt = v2 & conv2 & (kind == RES_UNF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            conv1   <= 1'b0;
            raw1    <= '0;
            mag1    <= '0;
            v2      <= 1'b0;
            conv2   <= 1'b0;
            zero2   <= 1'b1;
            raw2    <= '0;
            pos2    <= '0;
            norm2   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (adv) begin
            v1      <= i_valid;
            conv1   <= i_conv_op;
            raw1    <= i_data;
            mag1    <= mant_abs(i_data[MANTISSA_WIDTH-1:0]);
            v2      <= v1;
            conv2   <= conv1;
            zero2   <= zero;
            raw2    <= raw1;
            pos2    <= pos;
            norm2   <= FRACTION_WIDTH'(mag1 << (5'd23 - pos));
            o_valid <= v2;
            if (v2) o_data <= result;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ovf_cnt <= '0;
            o_unf_cnt <= '0;
        end else if (i_cnt_clear) begin
            o_ovf_cnt <= '0;
            o_unf_cnt <= '0;
        end else if (adv) begin
            if (ovf_evt && !(&o_ovf_cnt)) o_ovf_cnt <= o_ovf_cnt + 1'b1;
            if (unf_evt && !(&o_unf_cnt)) o_unf_cnt <= o_unf_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fp32_packed_to_ieee_converter.sv
// Bench for the packed-to-IEEE converter: directed vectors, backpressure,
// mid-stream reset, counter saturation/clear and randomized streaming.
module tb_fp32_packed_to_ieee_converter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_conv_op = 1'b0;
    logic [31:0] i_data = 32'h0;
    logic        o_ready = 1'b0;
    logic        i_cnt_clear = 1'b0;
    logic        i_ready, o_valid;
    logic [31:0] o_data;
    logic [15:0] o_ovf_cnt, o_unf_cnt;

    int checks = 0;
    int errors = 0;

    // Word-level model: three pipeline slots holding {ovf, unf, data}.
    logic        mv [3];
    logic [33:0] mr [3];
    int          exp_ovf, exp_unf;

    fp32_packed_to_ieee_converter #(.CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_conv_op   (i_conv_op),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .i_cnt_clear (i_cnt_clear),
        .o_ovf_cnt   (o_ovf_cnt),
        .o_unf_cnt   (o_unf_cnt)
    );

    always #5 clk = ~clk;

    // value = mant * 2^-22 * 2^(exp-127); returns {ovf, unf, ieee word}
    function automatic logic [33:0] ref_model(input logic conv, input logic [31:0] d);
        int ex, m, mag, p, e;
        logic s;
        logic [31:0] frac;
        if (!conv) return {2'b00, d};
        ex = int'(d[31:24]);
        m  = int'(d[23:0]);
        if (m >= 32'h0080_0000) m = m - 32'h0100_0000;
        s   = (m < 0);
        mag = s ? -m : m;
        if (mag == 0) return 34'h0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = ex + p - 22;
        if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
        if (e <= 0) return {2'b01, s, 31'h0};
        frac = 32'((mag - (1 << p)) << (23 - p));
        return {2'b00, s, e[7:0], frac[22:0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mv[k] = 1'b0;
            mr[k] = 34'h0;
        end
        exp_ovf = 0;
        exp_unf = 0;
    endtask

    task automatic cycle(input logic v, input logic conv, input logic [31:0] d,
                         input logic rdy, input logic clr, output logic acc);
        logic adv;
        @(negedge clk);
        o_ready = rdy;
        i_valid = v;
        i_conv_op = conv;
        i_data = d;
        i_cnt_clear = clr;
        #1;
        adv = !mv[2] || rdy;
        checks++;
        if (o_valid !== mv[2]) begin
            errors++;
            $display("FAIL o_valid: got %b expected %b at %0t", o_valid, mv[2], $time);
        end
        if (mv[2]) begin
            checks++;
            if (o_data !== mr[2][31:0]) begin
                errors++;
                $display("FAIL o_data: got %h expected %h at %0t", o_data, mr[2][31:0], $time);
            end
        end
        checks++;
        if (i_ready !== adv) begin
            errors++;
            $display("FAIL i_ready: got %b expected %b at %0t", i_ready, adv, $time);
        end
        checks++;
        if (o_ovf_cnt !== 16'(exp_ovf) || o_unf_cnt !== 16'(exp_unf)) begin
            errors++;
            $display("FAIL counters: got ovf %0d unf %0d expected ovf %0d unf %0d at %0t",
                     o_ovf_cnt, o_unf_cnt, exp_ovf, exp_unf, $time);
        end
        acc = v && adv;
        if (adv) begin
            if (mv[1] && mr[1][33] && exp_ovf < 65535) exp_ovf++;
            if (mv[1] && mr[1][32] && exp_unf < 65535) exp_unf++;
            mv[2] = mv[1];
            mr[2] = mr[1];
            mv[1] = mv[0];
            mr[1] = mr[0];
            mv[0] = v;
            mr[0] = ref_model(conv, d);
        end
        if (clr) begin
            exp_ovf = 0;
            exp_unf = 0;
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 32'h0 || o_ovf_cnt !== 16'h0 ||
            o_unf_cnt !== 16'h0 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid %b data %h ovf %0d unf %0d rdy %b expected 0 0 0 0 1",
                     o_valid, o_data, o_ovf_cnt, o_unf_cnt, i_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] vin  [8] = '{32'h7F40_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h807F_FFFF,
                                  32'hFF40_0000, 32'h0040_0000, 32'h5500_0000, 32'hDEAD_BEEF};
        logic        vcv  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] vout [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 32'h407F_FFFE,
                                  32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF};
        logic [15:0] vovf [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
        logic [15:0] vunf [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
        logic acc;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vcv[i], vin[i], 1'b1, 1'b0, acc);
            for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
            checks++;
            if (o_valid !== 1'b1 || o_data !== vout[i]) begin
                errors++;
                $display("FAIL directed_%0d: got valid %b data %h expected valid 1 data %h",
                         i, o_valid, o_data, vout[i]);
            end
            checks++;
            if (o_ovf_cnt !== vovf[i] || o_unf_cnt !== vunf[i]) begin
                errors++;
                $display("FAIL directed_cnt_%0d: got ovf %0d unf %0d expected ovf %0d unf %0d",
                         i, o_ovf_cnt, o_unf_cnt, vovf[i], vunf[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [5];
        logic acc, rdy, saw_low;
        int idx, popped;
        for (int i = 0; i < 5; i++) w[i] = {8'(8'h70 + i), 24'(24'h40_0000 + i * 24'h1235)};
        idx = 0;
        popped = 0;
        saw_low = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rdy = !(c >= 3 && c < 7);
            cycle(idx < 5, 1'b1, w[idx < 5 ? idx : 0], rdy, 1'b0, acc);
            if (!i_ready) saw_low = 1'b1;
            if (o_valid && rdy) popped++;
            if (acc) idx++;
        end
        checks++;
        if (saw_low !== 1'b1 || idx != 5 || popped != 5) begin
            errors++;
            $display("FAIL backpressure: got ready_low %b accepted %0d delivered %0d expected 1 5 5",
                     saw_low, idx, popped);
        end
    endtask

    task automatic test_random();
        logic acc, v, c, rdy, clr;
        logic [31:0] d;
        for (int n = 0; n < 2000; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            d   = $urandom;
            case ($urandom_range(0, 5))
                0: d[31:24] = 8'($urandom_range(0, 3));
                1: d[31:24] = 8'($urandom_range(250, 255));
                2: d[23:0]  = 24'($urandom_range(0, 3));
                3: d[23:0]  = 24'h80_0000;
                default: ;
            endcase
            cycle(v, c, d, rdy, clr, acc);
        end
    endtask

    task automatic test_reset_midstream();
        logic acc;
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b0, acc);
        @(negedge clk);
        #2;
        rst = 1'b1;
        i_valid = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ovf_cnt !== 16'h0 || o_unf_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midstream_reset: got valid %b ovf %0d unf %0d expected 0 0 0",
                     o_valid, o_ovf_cnt, o_unf_cnt);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_counters();
        logic acc;
        for (int n = 0; n < 65540; n++) cycle(1'b1, 1'b1, 32'hFF40_0000, 1'b1, 1'b0, acc);
        checks++;
        if (o_ovf_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL ovf_saturate: got %h expected ffff", o_ovf_cnt);
        end
        cycle(1'b1, 1'b1, 32'hFF40_0000, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
        checks++;
        if (o_ovf_cnt !== 16'h0 || o_valid !== 1'b1 || o_data !== 32'h7F80_0000) begin
            errors++;
            $display("FAIL clear_vs_inc: got ovf %h valid %b data %h expected 0 1 7f800000",
                     o_ovf_cnt, o_valid, o_data);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
        checks++;
        if (o_ovf_cnt !== 16'h0) begin
            errors++;
            $display("FAIL clear_after: got ovf %h expected 0", o_ovf_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midstream();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
